// File: rtl/calc_sched_pkg.sv
// Shared types and constants for the round-robin calculate scheduler.
package calc_sched_pkg;

  typedef enum logic [1:0] {
    S_ARB  = 2'd0,
    S_CALC = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  // Datapath threshold: results are zero unless signed a+b exceeds this.
  // The scheduler never looks at it; it documents what the datapath does.
  localparam int THRESH = 1000;

  // Width of a requester index.
  function automatic int id_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/calc_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above the
// pointer, wrapping modulo NUM_REQ.
module calc_rr_arbiter
  import calc_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_idx,
  output logic               o_any_valid
);

  // Rotating priority search; the first hit wins and later hits are masked.
  always_comb begin
    int  j;
    logic found;
    o_gnt     = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(i_rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && i_req_valid[j]) begin
        found     = 1'b1;
        o_gnt[j]  = 1'b1;
        o_gnt_idx = ID_W'(j);
      end
    end
  end

  assign o_any_valid = |i_req_valid;

endmodule

// File: rtl/calc_rr_sched.sv
// Round-robin scheduler sharing one calculate datapath among NUM_REQ
// requesters, with a tagged response channel and saturating statistics.
module calc_rr_sched
  import calc_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        ap_start,
  output logic                        ap_idle,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic                        calc_ap_start,
  input  logic                        calc_ap_done,
  output logic [DATA_W-1:0]           calc_a,
  output logic [DATA_W-1:0]           calc_b,
  input  logic [DATA_W-1:0]           calc_ap_return,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [CNT_W-1:0]            op_count,
  output logic [CNT_W-1:0]            zero_count
);

  localparam int ID_W = id_w(NUM_REQ);

  state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [DATA_W-1:0]   r_calc_a, r_calc_b, r_rsp_data;
  logic [ID_W-1:0]     r_rsp_id;
  logic [CNT_W-1:0]    r_op_count, r_zero_count;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_gnt_idx;
  logic                w_any;
  logic                w_grant;
  logic                w_calc_done;
  logic                w_rsp_fire;
  logic [DATA_W-1:0]   w_a_sel, w_b_sel;

  calc_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req_valid (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_gnt       (w_gnt),
    .o_gnt_idx   (w_gnt_idx),
    .o_any_valid (w_any)
  );

  // A grant is only issued from S_ARB; reset suppresses it so nothing is
  // handed out in the cycle that abandons an op.
  assign w_grant     = (r_state == S_ARB) && ap_start && w_any && !ap_rst;
  assign w_calc_done = (r_state == S_CALC) && calc_ap_done;
  assign w_rsp_fire  = (r_state == S_RSP) && rsp_ready;

  assign w_a_sel = req_a[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_b_sel = req_b[int'(w_gnt_idx)*DATA_W +: DATA_W];

  assign req_ready     = w_grant ? w_gnt : '0;
  assign ap_idle       = (r_state == S_ARB) && !w_grant;
  assign calc_ap_start = (r_state == S_CALC);
  assign rsp_valid     = (r_state == S_RSP);
  assign calc_a        = r_calc_a;
  assign calc_b        = r_calc_b;
  assign rsp_data      = r_rsp_data;
  assign rsp_id        = r_rsp_id;
  assign op_count      = r_op_count;
  assign zero_count    = r_zero_count;

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_state <= S_ARB;
    else        r_state <= w_state_nxt;
  end

  // Next-state: arbitrate, wait for datapath done, wait for response accept.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ARB:   if (w_grant)      w_state_nxt = S_CALC;
      S_CALC:  if (calc_ap_done) w_state_nxt = S_RSP;
      S_RSP:   if (rsp_ready)    w_state_nxt = S_ARB;
      default:                   w_state_nxt = S_ARB;
    endcase
  end

  // Operand/result capture, pointer advance and saturating statistics.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_rr_ptr     <= '0;
      r_calc_a     <= '0;
      r_calc_b     <= '0;
      r_rsp_data   <= '0;
      r_rsp_id     <= '0;
      r_op_count   <= '0;
      r_zero_count <= '0;
    end else begin
      if (w_grant) begin
        r_calc_a <= w_a_sel;
        r_calc_b <= w_b_sel;
        r_rsp_id <= w_gnt_idx;
      end
      if (w_calc_done) r_rsp_data <= calc_ap_return;
      if (w_rsp_fire) begin
        // Next search starts just past the requester that was served.
        r_rr_ptr <= (r_rsp_id == ID_W'(NUM_REQ-1)) ? '0 : r_rsp_id + ID_W'(1);
        if (r_op_count != '1) r_op_count <= r_op_count + CNT_W'(1);
        if (r_rsp_data == '0 && r_zero_count != '1)
          r_zero_count <= r_zero_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_calc_rr_sched.sv
// Directed bench for calc_rr_sched: vector table plus hand sequences for
// back-pressure, slow datapath, gating/reset, rotation and saturation.
module tb_calc_rr_sched;

  logic         ap_clk = 1'b0;
  logic         ap_rst, ap_start, ap_idle;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic         calc_ap_start, calc_ap_done;
  logic [31:0]  calc_a, calc_b, calc_ap_return;
  logic         rsp_valid, rsp_ready;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic [15:0]  op_count, zero_count;
  logic         dp_stall;

  // Second instance: 3 requesters, 4-bit counters.
  logic         s_rst, s_ap_start, s_ap_idle;
  logic [2:0]   s_req_valid, s_req_ready;
  logic [95:0]  s_req_a, s_req_b;
  logic         s_calc_ap_start, s_calc_ap_done;
  logic [31:0]  s_calc_a, s_calc_b, s_calc_ap_return;
  logic         s_rsp_valid, s_rsp_ready;
  logic [31:0]  s_rsp_data;
  logic [1:0]   s_rsp_id;
  logic [3:0]   s_op_count, s_zero_count;

  int checks = 0;
  int failures = 0;
  int exp_op = 0;
  int exp_zero = 0;

  always #5 ap_clk = ~ap_clk;

  function automatic logic [31:0] calc_fn(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    return ($signed(s) > 32'sd1000) ? (s & 32'h7FFF_FFFF) : 32'd0;
  endfunction

  assign calc_ap_return   = calc_fn(calc_a, calc_b);
  assign calc_ap_done     = calc_ap_start & ~dp_stall;
  assign s_calc_ap_return = calc_fn(s_calc_a, s_calc_b);
  assign s_calc_ap_done   = s_calc_ap_start;

  calc_rr_sched dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_idle(ap_idle),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .calc_ap_start(calc_ap_start), .calc_ap_done(calc_ap_done),
    .calc_a(calc_a), .calc_b(calc_b), .calc_ap_return(calc_ap_return),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .op_count(op_count), .zero_count(zero_count)
  );

  calc_rr_sched #(.NUM_REQ(3), .DATA_W(32), .CNT_W(4)) dut_s (
    .ap_clk(ap_clk), .ap_rst(s_rst), .ap_start(s_ap_start), .ap_idle(s_ap_idle),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_a(s_req_a), .req_b(s_req_b),
    .calc_ap_start(s_calc_ap_start), .calc_ap_done(s_calc_ap_done),
    .calc_a(s_calc_a), .calc_b(s_calc_b), .calc_ap_return(s_calc_ap_return),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
    .rsp_id(s_rsp_id), .op_count(s_op_count), .zero_count(s_zero_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
  endtask

  task automatic count_rsp(input logic [31:0] d);
    if (exp_op < 65535) exp_op++;
    if (d == 32'd0 && exp_zero < 65535) exp_zero++;
  endtask

  // One isolated op on requester id; stall = extra cycles done is held low.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int stall);
    int n;
    req_valid = 4'(1 << id);
    set_op(id, a, b);
    ap_start  = 1'b1;
    rsp_ready = 1'b1;
    #1;
    n = 0;
    while (req_ready == 4'd0 && n < 20) begin
      step();
      n++;
    end
    chk("grant", 32'(req_ready), 32'(1 << id));
    step();
    req_valid = 4'd0;
    dp_stall  = (stall != 0);
    #1;
    chk("calc_start", 32'(calc_ap_start), 32'd1);
    chk("calc_a", calc_a, a);
    chk("calc_b", calc_b, b);
    for (int k = 0; k < stall; k++) begin
      chk("stall_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    dp_stall = 1'b0;
    step();
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", rsp_data, exp);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    step();
    count_rsp(exp);
    chk("op_count", 32'(op_count), 32'(exp_op));
    chk("zero_count", 32'(zero_count), 32'(exp_zero));
    chk("idle_after", 32'(ap_idle), 32'd1);
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 32'd600,        32'd500,        32'd1100};
    vecs[1] = '{1, 32'd400,        32'd500,        32'd0};
    vecs[2] = '{2, 32'd1000,       32'd0,          32'd0};
    vecs[3] = '{3, 32'd1000,       32'd1,          32'd1001};
    vecs[4] = '{0, 32'hFFFF_FFFB,  32'd2000,       32'd1995};
    vecs[5] = '{1, 32'h7FFF_FFFF,  32'd1,          32'd0};
    vecs[6] = '{2, 32'h4000_0000,  32'h3FFF_FFFF,  32'h7FFF_FFFF};
    vecs[7] = '{3, 32'h8000_0000,  32'h8000_0000,  32'd0};
    vecs[8] = '{0, 32'd2000,       32'hFFFF_FC19,  32'd1001};

    ap_rst = 1'b1; ap_start = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0; dp_stall = 1'b0;
    s_rst = 1'b1; s_ap_start = 1'b0; s_req_valid = '0; s_req_a = '0; s_req_b = '0;
    s_rsp_ready = 1'b0;
    step(); step();

    // Reset state
    chk("rst_idle", 32'(ap_idle), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_calc_start", 32'(calc_ap_start), 32'd0);
    chk("rst_calc_a", calc_a, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_zero_count", 32'(zero_count), 32'd0);
    ap_rst = 1'b0;
    step();

    // Table of isolated ops
    for (int v = 0; v < 9; v++)
      do_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].exp, 0);

    // Back-pressure: response held 5 cycles, no grants meanwhile
    req_valid = 4'b0100; set_op(2, 32'd3000, 32'd4);
    ap_start = 1'b1; rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0001; set_op(0, 32'd7000, 32'd0);
    #1;
    chk("bp_calc_no_ready", 32'(req_ready), 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", rsp_data, 32'd3004);
      chk("bp_rsp_id", 32'(rsp_id), 32'd2);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    count_rsp(32'd3004);
    chk("bp_op_count", 32'(op_count), 32'(exp_op));
    chk("bp_next_grant", 32'(req_ready), 32'h1);
    do_op(0, 32'd7000, 32'd0, 32'd7000, 0);

    // Slow datapath: done withheld 3 cycles
    do_op(1, 32'd1500, 32'd1, 32'd1501, 3);

    // Gating: no grant while ap_start is low
    ap_start = 1'b0; req_valid = 4'b0100; set_op(2, 32'd5000, 32'd5);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("gate_idle", 32'(ap_idle), 32'd1);
      chk("gate_no_ready", 32'(req_ready), 32'd0);
      step();
    end
    ap_start = 1'b1;
    #1;
    chk("gate_grant", 32'(req_ready), 32'h4);
    step();
    // Reset in S_CALC abandons the op
    ap_rst = 1'b1;
    #1;
    chk("pre_rst_calc", 32'(calc_ap_start), 32'd1);
    step();
    ap_rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 32'(2000 + i), 32'd0);
    req_valid = 4'b1101;
    #1;
    exp_op = 0; exp_zero = 0;
    chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_calc_start", 32'(calc_ap_start), 32'd0);
    chk("mrst_op_count", 32'(op_count), 32'd0);
    chk("mrst_zero_count", 32'(zero_count), 32'd0);
    chk("mrst_rsp_data", rsp_data, 32'd0);
    chk("mrst_grant0", 32'(req_ready), 32'h1);

    // Rotation: all valid, one op every 3 cycles, order 0,1,2,3,0
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      step();
      chk("rr_calc_no_ready", 32'(req_ready), 32'd0);
      step();
      chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rr_rsp_id", 32'(rsp_id), 32'(k % 4));
      chk("rr_rsp_data", rsp_data, 32'(2000 + (k % 4)));
      step();
      count_rsp(32'(2000 + (k % 4)));
      chk("rr_op_count", 32'(op_count), 32'(exp_op));
    end
    req_valid = 4'd0;

    // Saturation on 4-bit counters, 3 requesters (non power-of-two wrap)
    s_rst = 1'b0; s_ap_start = 1'b1; s_rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_req_a[i*32 +: 32] = 32'd1;
      s_req_b[i*32 +: 32] = 32'd1;
    end
    s_req_valid = 3'b111;
    #1;
    for (int k = 0; k < 20; k++) begin
      int n;
      n = 0;
      while (!s_rsp_valid && n < 10) begin
        step();
        n++;
      end
      chk("sat_rsp_valid", 32'(s_rsp_valid), 32'd1);
      chk("sat_rsp_data", s_rsp_data, 32'd0);
      if (k < 6) chk("sat_rsp_id", 32'(s_rsp_id), 32'(k % 3));
      step();
      chk("sat_op_count", 32'(s_op_count), 32'((k + 1 > 15) ? 15 : k + 1));
      chk("sat_zero_count", 32'(s_zero_count), 32'((k + 1 > 15) ? 15 : k + 1));
    end
    s_req_valid = 3'd0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_rr_sched.md
Name: calc_rr_sched

Overview:
Round-robin scheduler that shares one instance of the team's combinational calculate datapath among NUM_REQ requesters. The datapath computes a 31-bit masked sum, or 0 unless the signed 32-bit sum of a and b exceeds 1000. The block accepts operand pairs over per-requester valid/ready, drives the datapath with an ap_ctrl_hs-style start/done handshake, and captures the result. It returns the result, tagged with the requester ID, on a shared response channel, and keeps saturating operation and zero-result counters.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 32, operand and result width
CNT_W, 16, width of the statistics counters

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous active-high reset
ap_start  in  1  scheduler enable; no new grant is issued while low
ap_idle  out  1  high in S_ARB when no grant is being issued
req_valid  in  NUM_REQ  operand pair valid, one bit per requester
req_ready  out  NUM_REQ  one-hot, pulses for one cycle on the granted requester
req_a  in  NUM_REQ*DATA_W  operand a; requester i occupies bits [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  operand b, packed like req_a
calc_ap_start  out  1  start to the datapath
calc_ap_done  in  1  datapath done
calc_a  out  DATA_W  registered operand a
calc_b  out  DATA_W  registered operand b
calc_ap_return  in  DATA_W  datapath result
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_data  out  DATA_W  captured result
rsp_id  out  $clog2(NUM_REQ)  requester index of the response
op_count  out  CNT_W  completed responses, saturating
zero_count  out  CNT_W  completed responses with rsp_data==0, saturating

Behaviour:
- Reset (synchronous, ap_rst high at a rising edge):
  - state=S_ARB, rr_ptr=0.
  - All registered outputs are 0: req_ready, calc_ap_start, calc_a, calc_b, rsp_valid, rsp_data, rsp_id, op_count, zero_count.
  - ap_idle=1.
  - Reset mid-operation abandons the in-flight op and sends no response.
- S_ARB:
  - If ap_start=1 and any req_valid is set, grant the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - In that cycle: req_ready[g]=1 combinationally; latch req_a/req_b slice g into calc_a/calc_b and g into rsp_id; go to S_CALC.
  - Otherwise stay; ap_idle=1.
- S_CALC:
  - calc_ap_start=1, operands held stable.
  - When calc_ap_done=1, capture calc_ap_return into rsp_data and go to S_RSP.
  - With the combinational datapath (done = start) this takes exactly one cycle. Multi-cycle datapaths are tolerated: wait with no timeout.
- S_RSP:
  - rsp_valid=1; rsp_data and rsp_id held stable until the handshake.
  - On rsp_valid&rsp_ready: rr_ptr=(rsp_id+1) mod NUM_REQ; op_count+=1; zero_count+=1 if rsp_data==0; go to S_ARB.
  - Both counters saturate at all-ones.
- ap_start dropping during S_CALC or S_RSP does not abort; the op completes normally and no new grant follows.
- Latency: req_ready to rsp_valid is 2 cycles with a combinational datapath. Peak throughput is one op per 3 cycles.
- Fairness: a requester holding valid continuously is granted within NUM_REQ grants.
- req_ready is never asserted outside S_ARB and never on more than one requester.
- Requester protocol: valid stays high until ready; operands must be stable while valid.

Decomposition:
- Package calc_sched_pkg holds:
  - state enum {S_ARB, S_CALC, S_RSP}, 2-bit;
  - ID_W = $clog2(NUM_REQ) helper;
  - the THRESH=1000 constant, for bench reference only.
- One sub-module, calc_rr_arbiter: purely combinational. Inputs req_valid and rr_ptr; outputs a one-hot grant, the encoded index, and any_valid.

Test Plan:
- Single op: req 0 valid, a=600, b=500, rsp_ready=1 -> req_ready[0] pulse; 2 cycles later rsp_valid, rsp_data=1100, rsp_id=0; op_count=1.
- Below threshold: req 1, a=400, b=500 -> rsp_data=0, rsp_id=1; zero_count=1.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; rsp every 3 cycles.
- Back-pressure: rsp_ready=0 for 5 cycles during S_RSP -> rsp_data/rsp_id stable; no req_ready pulses; completes when ready rises.
- Gating and reset: ap_start=0 with req 2 valid -> no grant, ap_idle=1. Then ap_start=1 and assert ap_rst in S_CALC -> no response, rr_ptr=0, counters 0, next grant is req 0 when it is valid.
- Saturation: CNT_W=4, run 20 zero-result ops (a=b=1) -> op_count=zero_count=15.
